// File: rtl/trs80_sound_if.sv
// Z80 I/O bus view of the sound block: write/read strobes, port address and data lanes.
interface trs80_sound_if;
  logic       io_wr_n;
  logic       io_rd_n;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;

  modport master (
    output io_wr_n, io_rd_n, addr, din,
    input  dout, dout_en
  );

  modport slave (
    input  io_wr_n, io_rd_n, addr, din,
    output dout, dout_en
  );
endinterface

// File: rtl/trs80_sound.sv
// TRS-80 port 0xFF cassette latch plus NUM_CH square-wave tone channels and a saturating mixer.
// Define SOUND_READBACK_EN to make the channel registers readable on their ports.
module trs80_sound #(
  parameter int unsigned NUM_CH    = 3,
  parameter logic [7:0]  BASE_PORT = 8'hF8,
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned AUDIO_W   = 4,
  parameter int unsigned CASS_AMP  = 4,
  parameter int unsigned CH_AMP    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  trs80_sound_if.slave       bus,
  input  logic               cass_in,
  output logic [AUDIO_W-1:0] audio
);
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SumW = AUDIO_W + 3;

  logic                wr_prev_q;
  logic                wr_commit;
  logic [7:0]          ch_off;
  logic                ch_hit;
  logic                ff_wr;
  logic [PreW-1:0]     pre_q, pre_d;
  logic                tick;
  logic [1:0]          cass_lvl_q, cass_lvl_d;
  logic                cass_s1_q, cass_s2_q, cass_s3_q;
  logic                cass_latch_q, cass_latch_d;
  logic [7:0]          per_lo_q [NUM_CH];
  logic [7:0]          per_lo_d [NUM_CH];
  logic [3:0]          per_hi_q [NUM_CH];
  logic [3:0]          per_hi_d [NUM_CH];
  logic                en_q     [NUM_CH];
  logic                en_d     [NUM_CH];
  logic [11:0]         cnt_q    [NUM_CH];
  logic [11:0]         cnt_d    [NUM_CH];
  logic                sq_q     [NUM_CH];
  logic                sq_d     [NUM_CH];
  logic [SumW-1:0]     sum;
  logic [AUDIO_W-1:0]  audio_d;
  logic                rd_hit;
  logic [7:0]          rd_data;

  // Commit only on the falling edge of the strobe so a held-low write acts once.
  assign wr_commit = !bus.io_wr_n && wr_prev_q;
  assign ch_off    = bus.addr - BASE_PORT;
  assign ch_hit    = ch_off < 8'(2 * NUM_CH);
  assign ff_wr     = wr_commit && (bus.addr == 8'hFF);

  assign tick  = (pre_q == PreW'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + PreW'(1);

  always_comb begin
    cass_lvl_d   = ff_wr ? bus.din[1:0] : cass_lvl_q;
    cass_latch_d = cass_latch_q;
    if (cass_s2_q && !cass_s3_q) begin
      cass_latch_d = 1'b1;
    end else if (ff_wr) begin
      cass_latch_d = 1'b0;
    end
  end

  // A write to a channel takes priority over that channel's tick in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      per_lo_d[i] = per_lo_q[i];
      per_hi_d[i] = per_hi_q[i];
      en_d[i]     = en_q[i];
      cnt_d[i]    = cnt_q[i];
      sq_d[i]     = sq_q[i];
      if (wr_commit && ch_hit && (ch_off[7:1] == 7'(i))) begin
        cnt_d[i] = '0;
        if (!ch_off[0]) begin
          per_lo_d[i] = bus.din;
        end else begin
          per_hi_d[i] = bus.din[3:0];
          en_d[i]     = bus.din[7];
          if (!bus.din[7]) sq_d[i] = 1'b0;
        end
      end else if (!en_q[i] || ({per_hi_q[i], per_lo_q[i]} == 12'd0)) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (tick) begin
        if (cnt_q[i] == {per_hi_q[i], per_lo_q[i]} - 12'd1) begin
          cnt_d[i] = '0;
          sq_d[i]  = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 12'd1;
        end
      end
    end
  end

  always_comb begin
    case (cass_lvl_q)
      2'b01:   sum = SumW'(2 * CASS_AMP);
      2'b10:   sum = '0;
      default: sum = SumW'(CASS_AMP);
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (sq_q[i]) sum = sum + SumW'(CH_AMP);
    end
    audio_d = (sum > SumW'((2 ** AUDIO_W) - 1)) ? {AUDIO_W{1'b1}} : sum[AUDIO_W-1:0];
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    if (bus.addr == 8'hFF) begin
      rd_hit  = 1'b1;
      rd_data = {cass_latch_q, 7'b0};
`ifdef SOUND_READBACK_EN
    end else if (ch_hit) begin
      rd_hit = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_off[7:1] == 7'(i)) begin
          rd_data = ch_off[0] ? {en_q[i], 3'b000, per_hi_q[i]} : per_lo_q[i];
        end
      end
`endif
    end
  end

  assign bus.dout    = rd_data;
  assign bus.dout_en = rd_hit && !bus.io_rd_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q    <= 1'b0;
      pre_q        <= '0;
      cass_lvl_q   <= '0;
      cass_s1_q    <= 1'b0;
      cass_s2_q    <= 1'b0;
      cass_s3_q    <= 1'b0;
      cass_latch_q <= 1'b0;
      audio        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per_lo_q[i] <= '0;
        per_hi_q[i] <= '0;
        en_q[i]     <= 1'b0;
        cnt_q[i]    <= '0;
        sq_q[i]     <= 1'b0;
      end
    end else begin
      wr_prev_q    <= bus.io_wr_n;
      pre_q        <= pre_d;
      cass_lvl_q   <= cass_lvl_d;
      cass_s1_q    <= cass_in;
      cass_s2_q    <= cass_s1_q;
      cass_s3_q    <= cass_s2_q;
      cass_latch_q <= cass_latch_d;
      audio        <= audio_d;
      for (int i = 0; i < NUM_CH; i++) begin
        per_lo_q[i] <= per_lo_d[i];
        per_hi_q[i] <= per_hi_d[i];
        en_q[i]     <= en_d[i];
        cnt_q[i]    <= cnt_d[i];
        sq_q[i]     <= sq_d[i];
      end
    end
  end
endmodule

// File: tb/tb_trs80_sound.sv
// Self-checking bench for trs80_sound: closed-form tone/mixer model compared against audio every clk.
module tb_trs80_sound;
  localparam int unsigned NumCh   = 3;
  localparam logic [7:0]  Base    = 8'hF8;
  localparam int          Pre     = 16;
  localparam int unsigned AudioW  = 4;
  localparam int          CassAmp = 4;
  localparam int          ChAmp   = 4;
`ifdef SOUND_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cass_in = 1'b0;
  logic [AudioW-1:0] audio;

  trs80_sound_if bus ();

  trs80_sound #(
    .NUM_CH    (NumCh),
    .BASE_PORT (Base),
    .PRESCALE  (Pre),
    .AUDIO_W   (AudioW),
    .CASS_AMP  (CassAmp),
    .CH_AMP    (ChAmp)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .cass_in (cass_in),
    .audio   (audio)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int e;  // rising edges since reset release
  int m_lvl;
  int m_en  [NumCh];
  int m_per [NumCh];
  int m_es  [NumCh];
  int m_s0  [NumCh];
  bit pend;
  logic [7:0] pa, pd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    e = 0; m_lvl = 0; pend = 0;
    for (int i = 0; i < NumCh; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_es[i] = 0; m_s0[i] = 0;
    end
  endtask

  // Square state after edge ed: toggles once per m_per ticks, ticks land on edges divisible by Pre.
  function automatic int m_sq(input int ch, input int ed);
    int n;
    if (m_en[ch] == 0 || m_per[ch] == 0) return 0;
    n = ed / Pre - m_es[ch] / Pre;
    return m_s0[ch] ^ ((n / m_per[ch]) & 1);
  endfunction

  function automatic int m_audio(input int ed);
    int s;
    case (m_lvl)
      1:       s = 2 * CassAmp;
      2:       s = 0;
      default: s = CassAmp;
    endcase
    for (int i = 0; i < NumCh; i++) s += m_sq(i, ed) * ChAmp;
    return (s > (1 << AudioW) - 1) ? (1 << AudioW) - 1 : s;
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] d);
    int off, ch;
    off = int'(a) - int'(Base);
    if (a == 8'hFF) begin
      m_lvl = int'(d[1:0]);
    end else if (off >= 0 && off < 2 * NumCh) begin
      ch = off / 2;
      m_s0[ch] = m_sq(ch, e - 1);
      m_es[ch] = e;
      if (off % 2 == 0) begin
        m_per[ch] = (m_per[ch] & 'hF00) | int'(d);
      end else begin
        m_per[ch] = (int'(d[3:0]) << 8) | (m_per[ch] & 'hFF);
        m_en[ch]  = int'(d[7]);
        if (!d[7]) m_s0[ch] = 0;
      end
    end
  endtask

  task automatic step();
    int want;
    @(posedge clk);
    e++;
    want = m_audio(e - 1);
    if (pend) begin
      apply(pa, pd);
      pend = 0;
    end
    #1;
    chk("audio", 32'(audio), 32'(want));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.addr = a; bus.din = d; bus.io_wr_n = 1'b0;
    pend = 1; pa = a; pd = d;
    step();
    bus.io_wr_n = 1'b1;
    step();
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic en, input logic [7:0] d, input string tag);
    bus.addr = a; bus.io_rd_n = 1'b0;
    #1;
    chk({tag, "_en"}, 32'(bus.dout_en), 32'(en));
    chk({tag, "_dout"}, 32'(bus.dout), 32'(d));
    bus.io_rd_n = 1'b1;
  endtask

  task automatic next_change(output int ed);
    logic [AudioW-1:0] prev;
    prev = audio;
    ed = -1000;
    for (int k = 0; k < 200; k++) begin
      step();
      if (audio !== prev) begin
        ed = e;
        break;
      end
    end
  endtask

  int e1, e2, e3;
  bit seen_sat;
  logic [7:0] lo_exp, hi_exp;

  initial begin
    bus.io_wr_n = 1'b1; bus.io_rd_n = 1'b1; bus.addr = 8'h00; bus.din = 8'h00;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_audio", 32'(audio), 32'd0);
    chk("rst_dout_en_idle", 32'(bus.dout_en), 32'd0);
    rd_chk(8'hFF, 1'b1, 8'h00, "rst_rd_ff");
    @(negedge clk);
    reset_n = 1'b1;
    run(4);

    // Cassette level map
    wr(8'hFF, 8'h01); chk("lvl01", 32'(audio), 32'd8);
    wr(8'hFF, 8'h02); chk("lvl10", 32'(audio), 32'd0);
    wr(8'hFF, 8'h03); chk("lvl11", 32'(audio), 32'd4);
    rd_chk(8'h10, 1'b0, 8'h00, "rd_unowned");

    // ch0 tone, period 3 -> toggle every 48 clk
    wr(8'hFF, 8'h02);
    wr(8'hF8, 8'h03);
    wr(8'hF9, 8'h80);
    next_change(e1); next_change(e2); next_change(e3);
    chk("half_period_a", 32'(e2 - e1), 32'd48);
    chk("half_period_b", 32'(e3 - e2), 32'd48);

    // Held-low strobe spanning a tick: one commit with the first-cycle data
    while ((e % Pre) != 14) step();
    bus.addr = 8'hF8; bus.din = 8'h05; bus.io_wr_n = 1'b0;
    pend = 1; pa = 8'hF8; pd = 8'h05;
    step();
    bus.din = 8'h07;
    run(9);
    bus.io_wr_n = 1'b1;
    run(200);

    // Mixer saturation: ch1/ch2 period 1 started in the same prescale window
    wr(8'hFF, 8'h01);
    while ((e % Pre) != 1) step();
    wr(8'hFA, 8'h01); wr(8'hFB, 8'h80); wr(8'hFC, 8'h01); wr(8'hFD, 8'h80);
    seen_sat = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (audio == 4'hF) seen_sat = 1'b1;
    end
    chk("saturation_seen", 32'(seen_sat), 32'd1);

    // Randomized programming, unowned writes ignored
    for (int it = 0; it < 6; it++) begin
      wr(8'hFF, 8'($urandom_range(0, 3)));
      for (int ch = 0; ch < NumCh; ch++) begin
        wr(Base + 8'(2 * ch + 1), 8'($urandom & 32'h70));
        wr(Base + 8'(2 * ch), 8'($urandom_range(1, 4)));
        if ($urandom_range(0, 1) == 1) wr(Base + 8'(2 * ch + 1), 8'(32'h80 | ($urandom & 32'h70)));
      end
      wr(8'($urandom_range(0, 247)), 8'($urandom));
      run($urandom_range(100, 300));
    end

    for (int ch = 0; ch < NumCh; ch++) begin
      lo_exp = Rb ? 8'(m_per[ch] & 'hFF) : 8'h00;
      hi_exp = Rb ? {m_en[ch][0], 3'b000, 4'(m_per[ch] >> 8)} : 8'h00;
      rd_chk(Base + 8'(2 * ch), Rb, lo_exp, "rd_lo");
      step();
      rd_chk(Base + 8'(2 * ch + 1), Rb, hi_exp, "rd_hi");
      step();
    end

    // Cassette input edge latch
    cass_in = 1'b1; run(4);
    rd_chk(8'hFF, 1'b1, 8'h80, "cass_set");
    wr(8'hFF, 8'h02);
    rd_chk(8'hFF, 1'b1, 8'h00, "cass_clr");
    cass_in = 1'b0; run(4);
    rd_chk(8'hFF, 1'b1, 8'h00, "cass_fall");
    cass_in = 1'b1; step(); step();
    wr(8'hFF, 8'h02);
    rd_chk(8'hFF, 1'b1, 8'h80, "cass_set_wins");

    // Asynchronous reset mid-tone
    wr(8'hFF, 8'h01);
    wr(8'hF8, 8'h02); wr(8'hF9, 8'h80);
    run(20);
    cass_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_audio", 32'(audio), 32'd0);
    rd_chk(8'hFF, 1'b1, 8'h00, "arst_ff");
    rd_chk(8'hF9, Rb, 8'h00, "arst_f9");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    run(4);
    chk("post_rst_lvl00", 32'(audio), 32'd4);
    wr(8'hF8, 8'h02); wr(8'hF9, 8'h80);
    next_change(e1); next_change(e2);
    chk("post_rst_half_period", 32'(e2 - e1), 32'd32);
    run(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trs80_sound.md
Name: trs80_sound

Overview:
- Parametrised successor to the fixed 2-bit cassette/audio latch on port 0xFF.
- Keeps port 0xFF cassette output level mapping and adds the Model I cassette-input edge latch, readable on port 0xFF bit 7.
- Adds NUM_CH programmable square-wave tone channels on I/O ports BASE_PORT.., plus a saturating mixer driving the 4-bit audio DAC pins.
- Sits on the Z80 I/O bus in the CPU clock domain; the top level muxes dout into cpuDataIn when dout_en is high.

Parameters:
NUM_CH, 3, number of tone channels, 1..4
BASE_PORT, 8'hF8, first channel register port; ports BASE_PORT..BASE_PORT+2*NUM_CH-1 must not include 8'hFF
PRESCALE, 16, clk cycles per tone tick, >=2
AUDIO_W, 4, mixer output width
CASS_AMP, 4, cassette unit amplitude
CH_AMP, 2, per-channel amplitude when square is high

Ports:
clk  in  1  CPU clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
io_wr_n  in  1  I/O write strobe (n_WR|n_IORQ), synchronous to clk
io_rd_n  in  1  I/O read strobe (n_RD|n_IORQ), synchronous to clk
addr  in  8  I/O port address (cpuAddress[7:0])
din  in  8  CPU data out
dout  out  8  read data
dout_en  out  1  high when a read hits a port owned by this block
cass_in  in  1  asynchronous cassette input
audio  out  AUDIO_W  mixed audio level

Behaviour:
- Reset (async, reset_n=0) clears all registers, counters, squares, the cass latch, the synchronizer and audio to 0.
- Write commit: strobe samples io_wr_n each clk. A write commits only on the first cycle with io_wr_n=0 and the previous sample =1, using addr/din from that cycle. A held-low strobe commits exactly once.
- Port 0xFF write:
  - cass_lvl <= din[1:0].
  - Cassette input latch cleared.
- Channel i, port BASE_PORT+2i:
  - per_lo <= din.
  - Channel counter cleared to 0; square unchanged.
- Channel i, port BASE_PORT+2i+1:
  - per_hi <= din[3:0]; en <= din[7].
  - Counter cleared to 0.
  - If din[7]=0, square cleared.
- Period: period = {per_hi, per_lo}, 12 bits.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is high for one clk when the count = PRESCALE-1.
- Channel step on tick, when en=1 and period!=0:
  - If cnt==period-1: cnt<=0 and sq<=~sq.
  - Otherwise cnt<=cnt+1.
  - sq therefore toggles every period ticks; full wave = 2*period*PRESCALE clk.
- Silent channel: en=0 or period=0 holds cnt=0, sq=0.
- Write vs tick: a register write and a tick on the same cycle for the same channel resolves as write wins; that tick is dropped for that channel only.
- Cassette input:
  - cass_in passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal sets cass_latch.
  - Set and clear (port 0xFF write) on the same cycle: set wins.
- Read decode (combinational):
  - dout_en = !io_rd_n && addr hits an owned port.
  - Port 0xFF: dout = {cass_latch, 7'b0}.
  - Any other port: dout = 8'h00.
- Cassette level map:
  - 00 -> CASS_AMP
  - 01 -> 2*CASS_AMP
  - 10 -> 0
  - 11 -> CASS_AMP
- Mixer:
  - sum = cass level + sum over i of (sq_i ? CH_AMP : 0), computed in AUDIO_W+3 bits.
  - audio <= min(sum, 2^AUDIO_W-1), registered.
  - Latency: 1 clk from a sq or cass_lvl change.
- Writes to unowned ports: ignored, no state change.

Optional Feature:
SOUND_READBACK_EN:
- Defined:
  - Channel ports are readable: dout_en is high for them.
  - BASE_PORT+2i returns per_lo.
  - BASE_PORT+2i+1 returns {en, 3'b0, per_hi}.
- Undefined:
  - Only port 0xFF is owned for reads.
  - Channel ports give dout_en=0, dout=0.

Test Plan:
- Reset then write 0xFF<=0x01 -> audio=8 one clk after commit; write 0x02 -> audio=0; write 0x03 -> audio=4.
- io_wr_n held low 10 clks on port 0xF8 with din=0x05, then din changed to 0x07 mid-strobe -> per_lo=0x05 and the counter is cleared exactly once.
- ch0: per_lo=0x03, hi port 0xF9<=0x80 -> sq0 toggles every 48 clk; with cass_lvl=2'b10, audio alternates 0/2 with 96-clk period.
- ch0 and ch1 enabled, sq high, plus cass_lvl=2'b01 -> sum 8+2+2=12, audio=12. With CH_AMP=4 and all three channels high -> 8+12=20, audio saturates at 15.
- cass_in 0->1 -> read 0xFF gives 0x80 with dout_en=1; write 0xFF -> reads 0x00. Edge on the same cycle as the write -> still reads 0x80.
- reset_n pulsed low mid-tone with channels enabled -> audio, dout, latch and counters are 0 immediately (async). With SOUND_READBACK_EN, read 0xF9 after reset gives 0x00.
